// File: rtl/vga_timing_480p.sv
// Raster sequencer for 640x480@60: steps sx/sy on the pixel enable and emits
// registered sync, display-enable, line/frame strobes and a frame counter.
module vga_timing_480p #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_pixel,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    always_comb begin
        sx_d          = sx_q;
        sy_d          = sy_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (clk_pixel) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
            end else begin
                sx_d = sx_q + 1'b1;
            end
            line_start_d  = (sx_d == '0);
            frame_start_d = (sx_d == '0) && (sy_d == '0);
        end
        // Decode from the next counter values so outputs line up with sx/sy.
        de_d        = (sx_d < H_ACT) && (sy_d < V_ACT);
        hsync_d     = ((sx_d >= HS_BEG) && (sx_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d     = ((sy_d >= VS_BEG) && (sy_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
        frame_cnt_d = frame_cnt_q + {15'd0, frame_start_d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q          <= H_LAST;
            sy_q          <= V_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign sx          = sx_q;
    assign sy          = sy_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_480p.sv
// Bench for vga_timing_480p: a full-size 480p instance plus a shrunken
// active-high-sync instance, both checked against a step-count raster model.
module tb_vga_timing_480p;

    localparam int S_HA = 10, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_pixel = 1'b0;

    logic [9:0]  sx_a, sy_a;
    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic [15:0] fc_a;
    logic [4:0]  sx_b, sy_b;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic [15:0] fc_b;

    vga_timing_480p dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_pixel   (clk_pixel),
        .sx          (sx_a),
        .sy          (sy_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .de          (de_a),
        .line_start  (ls_a),
        .frame_start (fs_a),
        .frame_cnt   (fc_a)
    );

    vga_timing_480p #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .SYNC_POL (1'b1), .CW (5)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_pixel   (clk_pixel),
        .sx          (sx_b),
        .sy          (sy_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .de          (de_b),
        .line_start  (ls_b),
        .frame_start (fs_b),
        .frame_cnt   (fc_b)
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_bad = 0;
    longint k = 0;       // accepted pixel steps since the last reset
    bit    stepped = 1'b0;
    int    hs_cnt = 0;
    int    ls_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Position is the (k-1)th pixel of the endless raster; k=0 is the parked reset state.
    task automatic check_model(input string pfx, input int ha, input int hf, input int hs,
                               input int hb, input int va, input int vf, input int vs,
                               input int vb, input bit pol,
                               input logic [31:0] gsx, input logic [31:0] gsy,
                               input logic ghs, input logic gvs, input logic gde,
                               input logic gls, input logic gfs, input logic [15:0] gfc);
        int ht, vt, ex, ey, fc;
        longint p;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (k == 0) begin
            ex = ht - 1;
            ey = vt - 1;
            fc = 0;
        end else begin
            p  = (k - 1) % (ht * vt);
            ex = int'(p % ht);
            ey = int'(p / ht);
            fc = int'(((k - 1) / (ht * vt) + 1) % 65536);
        end
        check_eq({pfx, "_sx"}, gsx, ex);
        check_eq({pfx, "_sy"}, gsy, ey);
        check_eq({pfx, "_de"}, {31'd0, gde}, {31'd0, (ex < ha) && (ey < va)});
        check_eq({pfx, "_hsync"}, {31'd0, ghs},
                 {31'd0, ((ex >= ha + hf) && (ex < ha + hf + hs)) ? pol : !pol});
        check_eq({pfx, "_vsync"}, {31'd0, gvs},
                 {31'd0, ((ey >= va + vf) && (ey < va + vf + vs)) ? pol : !pol});
        check_eq({pfx, "_line_start"}, {31'd0, gls}, {31'd0, stepped && ex == 0});
        check_eq({pfx, "_frame_start"}, {31'd0, gfs}, {31'd0, stepped && ex == 0 && ey == 0});
        check_eq({pfx, "_frame_cnt"}, {16'd0, gfc}, fc);
    endtask

    task automatic tick(input bit pix);
        clk_pixel = pix;
        @(posedge clk);
        stepped = reset_n && pix;
        if (stepped) k++;
        #1;
        check_model("a", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                    {22'd0, sx_a}, {22'd0, sy_a}, hs_a, vs_a, de_a, ls_a, fs_a, fc_a);
        check_model("b", S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1,
                    {27'd0, sx_b}, {27'd0, sy_b}, hs_b, vs_b, de_b, ls_b, fs_b, fc_b);
        if (stepped && k >= 1 && k <= 800 && hs_a == 1'b0) hs_cnt++;
        if (k >= 1 && k <= 801 && ls_a) ls_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Pixel enable held high during reset must be ignored.
        repeat (3) tick(1'b1);
        reset_n = 1'b1;
        tick(1'b0);
        tick(1'b1);
        check_eq("first_sx", {22'd0, sx_a}, 0);
        check_eq("first_sy", {22'd0, sy_a}, 0);
        check_eq("first_de", {31'd0, de_a}, 1);
        check_eq("first_fs", {31'd0, fs_a}, 1);
        check_eq("first_fc", {16'd0, fc_a}, 1);
        tick(1'b0);
        check_eq("fs_one_clk", {31'd0, fs_a}, 0);

        while (k < 810) begin
            tick(1'b1);
            tick(1'b0);
        end
        check_eq("hsync_width", hs_cnt, 96);
        check_eq("line_start_cnt", ls_cnt, 2);

        while (k < 5000) tick($urandom_range(0, 3) != 0);
        while (k < 36124) tick(1'b1);
        check_eq("park_sx", {22'd0, sx_a}, 123);
        check_eq("park_sy", {22'd0, sy_a}, 45);
        repeat (1000) tick(1'b0);
        check_eq("frozen_sx", {22'd0, sx_a}, 123);
        tick(1'b1);
        check_eq("resume_sx", {22'd0, sx_a}, 124);

        while (k < 36301) tick(1'(($urandom_range(0, 1))));
        #2;
        reset_n = 1'b0;
        k = 0;
        #1;
        check_eq("async_sx", {22'd0, sx_a}, 799);
        check_eq("async_sy", {22'd0, sy_a}, 524);
        check_eq("async_hsync", {31'd0, hs_a}, 1);
        check_eq("async_fc", {16'd0, fc_a}, 0);
        check_eq("async_b_hsync", {31'd0, hs_b}, 0);
        repeat (3) tick(1'b1);
        reset_n = 1'b1;
        tick(1'b1);
        check_eq("rerun_sx", {22'd0, sx_a}, 0);
        check_eq("rerun_fs", {31'd0, fs_a}, 1);
        check_eq("rerun_fc", {16'd0, fc_a}, 1);

        repeat (3000) tick($urandom_range(0, 4) != 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
